// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter (PARITY state under UART_TX_PARITY_EN)
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - byte handshake and serial line bundle for uart_tx_ctrl
interface uart_tx_ctrl_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_tx_ctrl_baudgen.sv
// rtl/uart_tx_ctrl_baudgen.sv - free-running bit-period tick, one pulse every clock_freq/baud_rate clocks
module baudgen #(
  parameter int baud_rate  = 9600,
  parameter int clock_freq = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic baud_tick
);

  localparam int DIV = clock_freq / baud_rate;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1; the tick is registered so the first one lands DIV clocks after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      baud_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      baud_tick <= 1'b1;
    end else begin
      cnt       <= cnt + CW'(1);
      baud_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller, 8N1 by default, even/odd parity bit when UART_TX_PARITY_EN is defined
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_ODD = 0
) (
  input logic           clk,
  input logic           rst,
  uart_tx_ctrl_if.slave bus
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           idx;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  baudgen #(
    .baud_rate (BAUD_RATE),
    .clock_freq(CLOCK_FREQ)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick)
  );

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

  // Frame sequencer; every line bit changes only on a baud tick, so each bit lasts one full tick period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      idx     <= '0;
      tx_q    <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid && ready_q) begin
            shift   <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            par_bit <= (^bus.tx_data) ^ (PARITY_ODD != 0);
`endif
            state   <= ARM;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          // Waiting for a tick aligns the start bit to the free-running bit grid
          if (baud_tick) begin
            state <= START;
            tx_q  <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            state <= DATA;
            tx_q  <= shift[0];
            shift <= shift >> 1;
            idx   <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx_q  <= par_bit;
`else
              state <= STOP;
              tx_q  <= LINE_IDLE;
`endif
            end else begin
              idx   <= idx + 3'd1;
              tx_q  <= shift[0];
              shift <= shift >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            state <= STOP;
            tx_q  <= LINE_IDLE;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            state   <= IDLE;
            tx_q    <= LINE_IDLE;
            idx     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl (frame length follows UART_TX_PARITY_EN)
module tb_uart_tx_ctrl;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic clk;
  logic rst;
  logic def_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int frames_cnt = 0;
  bit mon_busy = 0;

  logic [10:0] exp_q[$];
  int          start_q[$];
  vec_t        vecs[6];

  uart_tx_ctrl_if bus();

  uart_tx_ctrl #(
    .CLOCK_FREQ(50000000),
    .BAUD_RATE (5000000),
    .PARITY_ODD(0)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  baudgen #(
    .baud_rate (9600),
    .clock_freq(50000000)
  ) u_bg_def (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(def_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;
  always @(negedge clk) if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic send(input logic [7:0] d, input logic p, input bit push);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_before_send", 32'(n < 3000), 1);
    if (push) exp_q.push_back(mk_frame(d, p));
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || bus.tx_ready !== 1'b1) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n < 3000), 1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (bus.tx !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(n < 1000), 1);
  endtask

  // Line monitor: decodes each frame bit by bit and compares against the scoreboard
  initial begin : monitor
    logic        line_prev;
    logic [10:0] cap;
    logic [10:0] expf;
    bit          width_ok, busy_ok, early_done, aborted;
    line_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && line_prev === 1'b1 && bus.tx === 1'b0) begin
        mon_busy = 1;
        start_q.push_back(cyc);
        cap = '0;
        width_ok = 1;
        busy_ok = 1;
        early_done = 0;
        aborted = 0;
        for (int i = 0; i < NB * DIV; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          if (i % DIV == 0) cap[i / DIV] = bus.tx;
          else if (bus.tx !== cap[i / DIV]) width_ok = 0;
          if (bus.tx_busy !== 1'b1) busy_ok = 0;
          if (bus.tx_done !== 1'b0) early_done = 1;
        end
        if (!aborted) begin
          @(negedge clk);
          chk("done_at_frame_end", 32'(bus.tx_done), 1);
          @(negedge clk);
          chk("done_one_cycle", 32'(bus.tx_done), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            expf = exp_q.pop_front();
            chk("frame_bits", 32'(cap), 32'(expf));
          end
          chk("bit_width", 32'(width_ok), 1);
          chk("busy_in_frame", 32'(busy_ok), 1);
          chk("no_early_done", 32'(early_done), 0);
          frames_cnt++;
        end
        mon_busy = 0;
      end
      line_prev = rst ? 1'b1 : bus.tx;
    end
  end

  initial begin : main
    int n, m, d0, a0, f0, s0, gap;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h5A, 1'b0};
    vecs[2] = '{8'h07, 1'b1};
    vecs[3] = '{8'h01, 1'b1};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hC3, 1'b0};

    rst = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;

    // Reset held for 100 ns
    repeat (10) begin
      @(negedge clk);
      chk("rst_tx", 32'(bus.tx), 1);
      chk("rst_ready", 32'(bus.tx_ready), 1);
      chk("rst_busy", 32'(bus.tx_busy), 0);
      chk("rst_done", 32'(bus.tx_done), 0);
    end
    rst = 1'b0;

    // Default divider: 50 MHz / 9600 truncated
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (def_tick !== 1'b1 && n < 20000);
    chk("def_first_tick", n, 5208);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (def_tick !== 1'b1 && m < 20000);
    chk("def_tick_spacing", m, 5208);

    @(posedge clk);
    #1;

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      send(vecs[i].data, vecs[i].par, 1);
      wait_idle("table_frame_timeout");
      chk("table_done_pulses", done_cnt - d0, 1);
    end

    // Back-to-back with tx_valid held
    s0 = start_q.size();
    d0 = done_cnt;
    exp_q.push_back(mk_frame(8'h00, 1'b0));
    exp_q.push_back(mk_frame(8'hFF, 1'b0));
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_data = 8'hFF;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_ready_again", 32'(n < 3000), 1);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    wait_idle("b2b_timeout");
    chk("b2b_frames", start_q.size() - s0, 2);
    chk("b2b_done_pulses", done_cnt - d0, 2);
    if (start_q.size() >= s0 + 2) begin
      gap = start_q[s0 + 1] - (start_q[s0] + (NB - 1) * DIV);
      chk("b2b_gap", gap, 2 * DIV);
    end

    // tx_valid pulse and tx_data change while busy are ignored
    a0 = acc_cnt;
    f0 = frames_cnt;
    send(8'h5A, 1'b0, 1);
    wait_start();
    repeat (25) @(posedge clk);
    #1;
    bus.tx_data = 8'h3C;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    bus.tx_data = 8'hFF;
    wait_idle("busy_ignore_timeout");
    repeat (3 * DIV) @(posedge clk);
    #1;
    chk("busy_ignore_accepts", acc_cnt - a0, 1);
    chk("busy_ignore_frames", frames_cnt - f0, 1);
    chk("busy_ignore_idle_line", 32'(bus.tx), 1);

    // Reset during data bit 3 (0xF0 has bit 3 low so the line visibly snaps high)
    d0 = done_cnt;
    f0 = frames_cnt;
    send(8'hF0, 1'b0, 0);
    @(negedge clk);
    wait_start();
    repeat (45) @(negedge clk);
    chk("pre_rst_line_low", 32'(bus.tx), 0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(bus.tx), 1);
    chk("mid_rst_ready", 32'(bus.tx_ready), 1);
    chk("mid_rst_busy", 32'(bus.tx_busy), 0);
    chk("mid_rst_done", 32'(bus.tx_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * NB * DIV) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_frame", frames_cnt - f0, 0);
    @(posedge clk);
    #1;
    d0 = done_cnt;
    send(8'h81, 1'b0, 1);
    wait_idle("after_rst_timeout");
    chk("after_rst_done", done_cnt - d0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd), used only under PARITY_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port tx_data, input, 8 bits: byte to send.
REQ-007 The block SHALL have port tx_valid, input, 1 bit: tx_data valid.
REQ-008 The block SHALL have port tx_ready, output, 1 bit: byte accepted this cycle when tx_valid is also high.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port tx_busy, output, 1 bit: high when state is not IDLE.
REQ-011 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 DIV SHALL be CLOCK_FREQ/BAUD_RATE, truncated; baud_tick SHALL pulse one cycle every DIV clocks, free-running, first pulse DIV cycles after reset release.
REQ-013 The FSM SHALL have states IDLE, ARM, START, DATA, PARITY (PARITY_EN only), STOP; all outputs registered.
REQ-014 tx_ready SHALL be high only in IDLE; accept on tx_valid&&tx_ready: latch tx_data into the shift register, go to ARM.
REQ-015 ARM: tx=1; on baud_tick go to START with tx=0.
REQ-016 START: on baud_tick go to DATA, tx=bit0; data is sent LSB first, one bit per baud_tick, 3-bit index 0..7.
REQ-017 DATA, index 7 on baud_tick: go to PARITY if enabled, else STOP; tx=1 in STOP.
REQ-018 STOP: on baud_tick go to IDLE; tx_done high exactly in the first IDLE cycle.
REQ-019 Each line bit SHALL last exactly DIV cycles; frame = 10 bit periods (11 with parity).
REQ-020 With tx_valid held high, the gap between one frame's stop-bit start and the next start bit SHALL be exactly 2 bit periods of line high.
REQ-021 tx_valid while busy SHALL be ignored; tx_data changes after acceptance SHALL NOT affect the frame.

Reset
REQ-022 On rst, immediately and asynchronously: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, baud counter 0, index 0, shift register 0.
REQ-023 Reset mid-frame SHALL abort the frame without a tx_done pulse and SHALL drop the latched byte.

Configuration
REQ-024 Macro UART_TX_PARITY_EN SHALL, when defined, add state PARITY after DATA, sending XOR of the 8 data bits (inverted when PARITY_OD D=1... see REQ-003) for one bit period.
REQ-025 Without UART_TX_PARITY_EN, there SHALL be no PARITY state or logic; DATA index 7 goes straight to STOP.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state typedef, DATA_BITS=8, and the idle-line-level constant.
REQ-027 The bit-period tick SHALL come from one instance of the existing baudgen sub-module (parameters baud_rate, clock_freq; ports clk, rst, baud_tick).

Verification (CLOCK_FREQ=50000000, BAUD_RATE=5000000, DIV=10, unless noted)
REQ-028 Reset held 100 ns -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; defaults give DIV=5208 tick spacing.
REQ-029 Send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 with each bit 10 cycles; exactly one tx_done pulse; tx_busy high throughout the frame.
REQ-030 0x00 then 0xFF, tx_valid held -> both frames correct; line high exactly 20 cycles between first stop-bit start and second start bit.
REQ-031 Pulse tx_valid with 0x3C mid-frame and change tx_data during DATA -> no second accept; first frame bits unchanged.
REQ-032 Assert rst during DATA index 3 -> tx=1 in the same cycle, no tx_done; send 0x81 after release -> correct frame.
REQ-033 UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1, 11-bit frame, tx_done after 110 cycles from the start bit.
